// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and error-flag layout.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int ERR_PARITY = 0;
    localparam int ERR_FRAME  = 1;
    localparam int UART_ERR_W = 2;

    function automatic logic parity_of(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial input; resets to the idle level (1).
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes rx, samples bits at their centres, checks parity/stop
// and emits one-cycle data or error pulses per frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    output logic [7:0]            UART_data,
    output logic                  UART_data_valid,
    output logic [UART_ERR_W-1:0] UART_errors,
    output logic                  UART_errors_valid,
    output logic                  busy
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] MID      = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    logic          rxs;
    logic          rxs_prev;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_wrap;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          par_en_q;
    logic          par_odd_q;
    logic          par_err;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    // New bit enters at the top of the payload so the first bit ends up in bit 0.
    always_comb begin
        shift_next                = shift >> 1;
        shift_next[DATA_BITS-1]   = rxs;
        cnt_wrap                  = (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            rxs_prev          <= 1'b1;
            cnt               <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            par_en_q          <= 1'b0;
            par_odd_q         <= 1'b0;
            par_err           <= 1'b0;
            UART_data         <= '0;
            UART_data_valid   <= 1'b0;
            UART_errors       <= '0;
            UART_errors_valid <= 1'b0;
            busy              <= 1'b0;
        end else begin
            rxs_prev          <= rxs;
            UART_data_valid   <= 1'b0;
            UART_errors_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rxs_prev && !rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == MID) begin
                        // Restarting here puts every later sample at a bit centre.
                        cnt <= '0;
                        if (!rxs) begin
                            state     <= DATA;
                            bit_cnt   <= '0;
                            shift     <= '0;
                            par_en_q  <= parity_en;
                            par_odd_q <= parity_odd;
                            par_err   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    cnt <= cnt_wrap;
                    if (cnt == LAST) begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    cnt <= cnt_wrap;
                    if (cnt == LAST) begin
                        par_err <= (parity_of(shift) ^ rxs) != par_odd_q;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt_wrap;
                    if (cnt == LAST) begin
                        if (par_err || !rxs) begin
                            UART_errors[ERR_PARITY] <= par_err;
                            UART_errors[ERR_FRAME]  <= !rxs;
                            UART_errors_valid       <= 1'b1;
                        end else begin
                            UART_data       <= shift;
                            UART_data_valid <= 1'b1;
                        end
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                            cnt   <= '0;
                        end
                    end
                end
                BREAK: begin
                    // Leave only after the line has been high for a full bit period.
                    if (!rxs) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a frame-level expectation queue checked every cycle.
module tb_uart_rx_frame;

    localparam int CLK_DIV = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       parity_en;
    logic       parity_odd;
    logic [7:0] UART_data;
    logic       UART_data_valid;
    logic [1:0] UART_errors;
    logic       UART_errors_valid;
    logic       busy;

    uart_rx_frame #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx                (rx),
        .parity_en         (parity_en),
        .parity_odd        (parity_odd),
        .UART_data         (UART_data),
        .UART_data_valid   (UART_data_valid),
        .UART_errors       (UART_errors),
        .UART_errors_valid (UART_errors_valid),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          good;
        logic [7:0]  data;
        logic [1:0]  errs;
        bit          stop;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned pulse_log[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  model_data = 8'h00;
    logic        prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle out of reset, outputs are checked against the frame queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (UART_data_valid || UART_errors_valid) begin
                chk("valid_exclusive", {31'd0, UART_data_valid & UART_errors_valid}, 32'd0);
                if (q.size() == 0) begin
                    chk("spurious_pulse", {30'd0, UART_data_valid, UART_errors_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    pulse_log.push_back(cyc);
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_kind", {31'd0, UART_data_valid}, {31'd0, e.good});
                    chk("busy_at_pulse", {30'd0, prev_busy, busy}, e.stop ? 32'd2 : 32'd3);
                    if (e.good) model_data = e.data;
                    else chk("error_bits", {30'd0, UART_errors}, {30'd0, e.errs});
                end
            end else if (q.size() > 0 && cyc > q[0].cyc) begin
                chk("missing_pulse", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            chk("data_hold", {24'd0, UART_data}, {24'd0, model_data});
            prev_busy = busy;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    // Model: expected outcome and pulse time of a frame from its bits alone.
    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop);
        exp_t e;
        bit   pen;
        bit   perr;
        int   ones;
        pen    = parity_en;
        ones   = $countones(d) + (pen ? int'(pbit) : 0);
        perr   = pen && ((ones % 2 == 1) != parity_odd);
        e.good = !perr && stop;
        e.data = d;
        e.errs = {!stop, perr};
        e.stop = stop;
        e.cyc  = cyc + 3 + CLK_DIV / 2 + (9 + (pen ? 1 : 0)) * CLK_DIV;
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, UART_data}, 32'd0);
        chk("rst_errors", {30'd0, UART_errors}, 32'd0);
        chk("rst_valids", {30'd0, UART_data_valid, UART_errors_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Plain 8N1 frame
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(40);
        chk("t1_data", {24'd0, UART_data}, 32'hAA);

        // Even parity: correct then wrong parity bit; mid-frame parity_odd change ignored
        parity_en = 1'b1; parity_odd = 1'b0;
        send_frame(8'hDD, 1'b0, 1'b1);
        idle(40);
        chk("t2_good_data", {24'd0, UART_data}, 32'hDD);
        fork
            send_frame(8'hDD, 1'b1, 1'b1);
            begin repeat (60) @(negedge clk); parity_odd = 1'b1; end
        join
        parity_odd = 1'b0;
        idle(40);
        chk("t2_data_kept", {24'd0, UART_data}, 32'hDD);
        chk("t2_errors", {30'd0, UART_errors}, 32'h1);

        // Framing error followed by a held-low break
        parity_en = 1'b0;
        send_frame(8'hD1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("t3_busy_in_break", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        chk("t3_busy_idle", {31'd0, busy}, 32'd0);
        chk("t3_errors", {30'd0, UART_errors}, 32'h2);
        idle(20);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(40);
        chk("t3_next_data", {24'd0, UART_data}, 32'h81);

        // Short glitch rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_busy_start", {31'd0, busy}, 32'd1);
        repeat (14) @(negedge clk);
        chk("t4_busy_end", {31'd0, busy}, 32'd0);
        idle(20);

        // Back-to-back frames
        pulse_log.delete();
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h8D, 1'b0, 1'b1);
        idle(40);
        chk("t5_pulses", pulse_log.size(), 32'd2);
        if (pulse_log.size() == 2) chk("t5_spacing", pulse_log[1] - pulse_log[0], 32'd160);
        chk("t5_data", {24'd0, UART_data}, 32'h8D);

        // Reset in the middle of frame 0xF8
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_data = 8'h00;
        #1;
        chk("t6_rst_data", {24'd0, UART_data}, 32'd0);
        chk("t6_rst_errors", {30'd0, UART_errors}, 32'd0);
        chk("t6_rst_valids", {30'd0, UART_data_valid, UART_errors_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(300);
        send_frame(8'hAA, 1'b0, 1'b1);
        idle(40);
        chk("t6_next_data", {24'd0, UART_data}, 32'hAA);

        chk("pending_frames", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial UART receiver. Samples the asynchronous rx line, reassembles 8-bit frames and checks parity and stop bit.
- Produces the UART_data / UART_data_valid and UART_errors / UART_errors_valid pulses that the LED manager and the config manager consume.
- Sits between the board RX pin and the downstream consumers. Runs entirely in the UART clock domain.

Parameters:
- CLK_DIV, 16, clk cycles per bit period; legal range 4..65535; counter width = $clog2(CLK_DIV).
- DATA_BITS, 8, payload bits per frame, LSB first; the UART_data width stays 8 and unused MSBs read 0.

Ports:
- clk  input  1  UART clock.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to clk.
- parity_en  input  1  1 = frame carries a parity bit after the data bits; sampled at start-bit validation.
- parity_odd  input  1  1 = odd parity, 0 = even parity; sampled together with parity_en.
- UART_data  output  8  last received payload; holds its value until the next good frame.
- UART_data_valid  output  1  one-cycle pulse; asserted only for an error-free frame.
- UART_errors  output  2  bit0 = parity error, bit1 = framing error.
- UART_errors_valid  output  1  one-cycle pulse whenever a frame ends with any error bit set.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset, asynchronous, active-low:
  - State goes to IDLE. All counters clear.
  - UART_data = 0, UART_errors = 0, both valid outputs = 0, busy = 0.
  - The synchronizer flops reset to 1 (line idle).
  - Reset asserted mid-frame discards the partial frame, with no pulse.
- Input path: 2-flop synchronizer on rx. All decisions use the synchronized value rxs, which adds 2 cycles of latency.
- Bit timer: counts 0..CLK_DIV-1. "Mid-bit" = count == CLK_DIV/2 - 1 (integer division). The counter wraps at CLK_DIV-1.
- FSM states and transitions:
  - IDLE: rxs falling edge (previous 1, now 0) -> START; timer cleared, busy = 1.
  - START: at mid-bit, rxs == 0 -> DATA; bit timer restarts from that point so that subsequent samples land at bit centres; parity config latched. At mid-bit, rxs == 1 -> IDLE (glitch), with no output and busy = 0.
  - DATA: one sample per full bit period, shifted in LSB first. After DATA_BITS samples -> PARITY if the latched parity_en = 1, else -> STOP.
  - PARITY: sample one bit. Parity error = XOR(data, sampled bit) != latched parity_odd. -> STOP.
  - STOP: sample one bit; 0 = framing error.
    - No error: UART_data is updated and UART_data_valid pulses on the next clk.
    - Any error: UART_errors is updated, UART_errors_valid pulses on the next clk, and UART_data is unchanged.
    - Stop bit = 1 -> IDLE. Stop bit = 0 -> BREAK.
  - BREAK: wait until rxs == 1 for one full bit period, then -> IDLE. No further pulses while rx is held low.
- Latency: the valid pulse occurs 1 clk after the stop-bit mid-sample, which is about 2 + (1 + DATA_BITS + parity + 0.5) * CLK_DIV clks after the rx falling edge.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit mid-sample, so a start edge arriving half a bit later is caught; zero idle bits between frames is supported.
- UART_data_valid and UART_errors_valid are never high in the same cycle.
- UART_errors is not cleared by a later good frame; consumers qualify it with UART_errors_valid.
- parity_en / parity_odd changes mid-frame have no effect on the current frame.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - localparams ERR_PARITY = 0 and ERR_FRAME = 1;
  - the UART_ERR_W = 2 width constant, which the LED manager also uses.
- One natural sub-module, uart_rx_sync: the 2-flop synchronizer with reset-to-1, reused by future RX pins.

Test Plan:
1. CLK_DIV = 16, parity off; send 0xAA, 8N1 -> exactly one UART_data_valid pulse with UART_data = 0xAA, UART_errors_valid stays 0, busy falls at the stop mid-sample.
2. parity_en = 1, parity_odd = 0; send 0xDD with parity bit 0 (six ones, so even parity is correct) -> UART_data_valid with 0xDD. Resend 0xDD with parity bit 1 -> UART_errors_valid, UART_errors = 2'b01, UART_data still 0xDD.
3. Send 0xD1 with the stop bit driven 0, then hold rx low for 3 bit periods -> single UART_errors_valid with UART_errors = 2'b10, no second pulse; FSM reaches IDLE one bit period after rx returns high; the next 0x81 frame is received correctly.
4. Drive rx low for 4 clks only -> no pulses, busy returns to 0, FSM back in IDLE.
5. Two back-to-back frames 0x11 then 0x8D with zero idle bits -> two UART_data_valid pulses carrying 0x11 then 0x8D, spaced 10 * CLK_DIV clks apart.
6. Assert rst_n = 0 during the DATA state of frame 0xF8 -> all outputs 0 immediately (asynchronous), no pulse after release; the next 0xAA frame is received correctly.
